// File: rtl/rf_wport_arb.sv
// rf_wport_arb: arbiter/sequencer for the single register-file write port.
// Execute writeback has priority. Loads are buffered in a small FIFO.
// A starvation counter stalls execute so that a pending load is eventually written.
// Optional macro RF_WPORT_BYPASS_EN adds read-after-write bypass hints (byp_a/byp_b).
module rf_wport_arb #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              ex_valid,
  input  logic [4:0]        ex_addr,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [4:0]        ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              stall_ex,
  output logic              wr_en,
  output logic [4:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data
`ifdef RF_WPORT_BYPASS_EN
  ,
  input  logic [4:0]        rd_addr_a,
  input  logic [4:0]        rd_addr_b,
  output logic              byp_a,
  output logic              byp_b
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] SMAX     = SW'(STARVE_MAX);

  logic [FIFO_DEPTH-1:0][4:0]        fa_q, fa_d;
  logic [FIFO_DEPTH-1:0][DATA_W-1:0] fd_q, fd_d;
  logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              ld_ready_q, ld_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [4:0]        wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              empty, gnt_ld, gnt_ex, push, pop, do_wr;
  logic [4:0]        g_addr;
  logic [DATA_W-1:0] g_data;

  // Grant decision from registered state; a stalled execute is simply ignored this cycle
  always_comb begin
    empty    = (cnt_q == '0);
    stall_ex = (starve_q == SMAX) && !empty;
    gnt_ld   = stall_ex || (!ex_valid && !empty);
    gnt_ex   = !stall_ex && ex_valid;
    push     = ld_valid && ld_ready_q;
    pop      = gnt_ld;
    g_addr   = gnt_ld ? fa_q[rp_q] : ex_addr;
    g_data   = gnt_ld ? fd_q[rp_q] : ex_data;
    // r0 grants still consume the slot (and pop a load) but never reach the array
    do_wr    = (gnt_ld || gnt_ex) && (g_addr != 5'd0);
  end

  // Next-state: FIFO storage/pointers, ready flag, starvation counter, output stage
  always_comb begin
    fa_d = fa_q;
    fd_d = fd_q;
    if (push) begin
      fa_d[wp_q] = ld_addr;
      fd_d[wp_q] = ld_data;
    end
    wp_d  = wp_q + PW'(push);
    rp_d  = rp_q + PW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    // Registered ready: a pop out of a full FIFO is visible upstream one cycle later
    ld_ready_d = (cnt_d != FULL_CNT);

    starve_d = starve_q;
    if (gnt_ld || empty)
      starve_d = '0;
    else if (gnt_ex && (starve_q != SMAX))
      starve_d = starve_q + SW'(1);

    // Address/data hold when nothing is written to keep the decoder quiet
    wr_en_d   = do_wr;
    wr_addr_d = do_wr ? g_addr : wr_addr_q;
    wr_data_d = do_wr ? g_data : wr_data_q;
  end

  // State registers; reset drops any buffered loads
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      fa_q       <= '0;
      fd_q       <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      starve_q   <= '0;
      ld_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      fa_q       <= fa_d;
      fd_q       <= fd_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      ld_ready_q <= ld_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign ld_ready = ld_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

`ifdef RF_WPORT_BYPASS_EN
  // Read mux hint: the register being read is being written this very cycle
  assign byp_a = wr_en_q && (wr_addr_q == rd_addr_a) && (rd_addr_a != 5'd0);
  assign byp_b = wr_en_q && (wr_addr_q == rd_addr_b) && (rd_addr_b != 5'd0);
`endif

endmodule
